pipe_hazard_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage pipelined CPU; next generation of the ID-stage
//  exe_load interlock. Keeps shadow EXE/MEM records of in-flight writers; generates per-operand forwarding

---
 rtl/pipe_hazard_unit.sv | 94 +++++++++
 tb/tb_pipe_hazard_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: shadow EXE/MEM writer records, operand forwarding selects,
// load-use and multi-cycle multiply stalls. Define HAZ_FWD_EN to enable forwarding.
module pipe_hazard_unit #(
  parameter int unsigned AW      = 5,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic [AW-1:0] id_dst,
  input  logic          id_load,
  input  logic          id_mul,
  output logic          stall,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mul_busy
);

  localparam int unsigned MW = ($clog2(MUL_LAT) < 1) ? 1 : $clog2(MUL_LAT);

  typedef struct packed {
    logic          v;
    logic          w;
    logic [AW-1:0] dst;
    logic          ld;
  } rec_t;

  rec_t          e_q, e_d, m_q, m_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          use_a, use_b;
  logic          e_a, m_a, e_b, m_b;
  logic          hazard;

  function automatic logic hit(input rec_t r, input logic [AW-1:0] a);
    return r.v & r.w & (r.dst == a) & (a != '0);
  endfunction

  always_comb begin
    use_a = id_valid & id_use_rs;
    use_b = id_valid & id_use_rt;
    e_a   = use_a & hit(e_q, id_rs);
    m_a   = use_a & hit(m_q, id_rs);
    e_b   = use_b & hit(e_q, id_rt);
    m_b   = use_b & hit(m_q, id_rt);
`ifdef HAZ_FWD_EN
    // Only a load still in EXE cannot be forwarded; everything else is bypassed.
    hazard = (e_a | e_b) & e_q.ld;
    fwd_a  = (e_a & ~e_q.ld) ? 2'b01 : (m_a ? (m_q.ld ? 2'b11 : 2'b10) : 2'b00);
    fwd_b  = (e_b & ~e_q.ld) ? 2'b01 : (m_b ? (m_q.ld ? 2'b11 : 2'b10) : 2'b00);
`else
    hazard = e_a | m_a | e_b | m_b;
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
`endif
    mul_busy = (mcnt_q != '0);
    stall    = mul_busy | hazard;
  end

  always_comb begin
    e_d    = e_q;
    m_d    = m_q;
    mcnt_d = mcnt_q;
    if (mul_busy) begin
      m_d    = '0;
      mcnt_d = mcnt_q - MW'(1);
    end else if (hazard) begin
      m_d = e_q;
      e_d = '0;
    end else begin
      m_d = e_q;
      e_d = '{v: id_valid, w: id_wreg, dst: id_dst, ld: id_load};
      if (id_valid && id_mul && (MUL_LAT > 1))
        mcnt_d = MW'(MUL_LAT - 1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_q    <= '0;
      m_q    <= '0;
      mcnt_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      mcnt_q <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios then random instruction stream
// against an in-flight-instruction reference model.
module tb_pipe_hazard_unit;
  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 3;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          id_valid, id_use_rs, id_use_rt, id_wreg, id_load, id_mul;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          stall, mul_busy;
  logic [1:0]    fwd_a, fwd_b;

  pipe_hazard_unit #(.AW(AW), .MUL_LAT(LAT)) dut (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_dst(id_dst),
    .id_load(id_load), .id_mul(id_mul), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mul_busy(mul_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       v, urs, urt, w, ld, mul;
    bit [4:0] rs, rt, dst;
  } ins_t;

  typedef struct {
    bit v, w, ld;
    int dst;
  } slot_t;

  int    checks = 0;
  int    failures = 0;
  slot_t ex, mm;
  int    mrem;
  bit    exp_stall, exp_busy;
  bit [1:0] exp_fa, exp_fb;
  logic  s_stall, s_busy;
  logic [1:0] s_fa, s_fb;

  function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, bit w, int dst, bit ld, bit mul);
    ins_t i;
    i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
    i.w = w; i.dst = 5'(dst); i.ld = ld; i.mul = mul;
    return i;
  endfunction

  function automatic bit writes(slot_t s, int r);
    return s.v && s.w && (s.dst == r) && (r != 0);
  endfunction

  function automatic bit haz_of(bit used, int r);
    if (!used) return 1'b0;
`ifdef HAZ_FWD_EN
    return writes(ex, r) && ex.ld;
`else
    return writes(ex, r) || writes(mm, r);
`endif
  endfunction

  function automatic bit [1:0] src_of(bit used, int r);
`ifdef HAZ_FWD_EN
    if (!used) return 2'd0;
    if (writes(ex, r) && !ex.ld) return 2'd1;
    if (writes(mm, r)) return mm.ld ? 2'd3 : 2'd2;
`endif
    return 2'd0;
  endfunction

  task automatic model_reset();
    ex = '{0, 0, 0, 0};
    mm = '{0, 0, 0, 0};
    mrem = 0;
  endtask

  task automatic chk(string tag, logic [1:0] got, logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one ID instruction for one clock, compare against the model, then advance the model.
  task automatic run(ins_t i, string tag);
    bit hz;
    slot_t nw;
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs; id_use_rt = i.urt;
    id_wreg = i.w; id_dst = i.dst; id_load = i.ld; id_mul = i.mul;
    #1;
    hz        = haz_of(i.v && i.urs, i.rs) || haz_of(i.v && i.urt, i.rt);
    exp_busy  = (mrem > 0);
    exp_stall = exp_busy || hz;
    exp_fa    = src_of(i.v && i.urs, i.rs);
    exp_fb    = src_of(i.v && i.urt, i.rt);
    s_stall = stall; s_busy = mul_busy; s_fa = fwd_a; s_fb = fwd_b;
    chk({tag, "_stall"}, {1'b0, s_stall}, {1'b0, exp_stall});
    chk({tag, "_busy"},  {1'b0, s_busy},  {1'b0, exp_busy});
    chk({tag, "_fwd_a"}, s_fa, exp_fa);
    chk({tag, "_fwd_b"}, s_fb, exp_fb);
    @(posedge clock);
    if (exp_busy) begin
      mm = '{0, 0, 0, 0};
      mrem--;
    end else if (exp_stall) begin
      mm = ex;
      ex = '{0, 0, 0, 0};
    end else begin
      mm = ex;
      nw.v = i.v; nw.w = i.w; nw.ld = i.ld; nw.dst = int'(i.dst);
      ex = nw;
      if (i.v && i.mul && LAT > 1) mrem = LAT - 1;
    end
    @(negedge clock);
  endtask

  ins_t nop;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_dst = '0; id_load = 0; id_mul = 0;
    model_reset();
    @(negedge clock);
    chk("rst_stall", {1'b0, stall}, 2'd0);
    chk("rst_busy", {1'b0, mul_busy}, 2'd0);
    chk("rst_fwd_a", fwd_a, 2'd0);
    chk("rst_fwd_b", fwd_b, 2'd0);
    resetn = 1'b1;
    @(negedge clock);

    // r0 writer never creates a hazard; an invalid consumer never stalls
    run(mk(1, 1, 2, 1, 1, 1, 0, 0, 0), "t4a");
    run(mk(1, 0, 0, 1, 1, 1, 4, 0, 0), "t4b");
    chk("t4_r0_stall", {1'b0, s_stall}, 2'd0);
    chk("t4_r0_fwd_a", s_fa, 2'd0);
    run(mk(0, 4, 4, 1, 1, 0, 0, 0, 0), "t4c");
    chk("t4_invalid_stall", {1'b0, s_stall}, 2'd0);
    repeat (2) run(nop, "gap");

`ifdef HAZ_FWD_EN
    run(mk(1, 1, 2, 1, 1, 1, 3, 0, 0), "t1a");
    run(mk(1, 3, 5, 1, 1, 1, 4, 0, 0), "t1b");
    chk("t1_exe_fwd_a", s_fa, 2'd1);
    chk("t1_exe_stall", {1'b0, s_stall}, 2'd0);
    run(mk(1, 1, 2, 1, 1, 1, 3, 0, 0), "t1c");
    run(nop, "t1d");
    run(mk(1, 3, 5, 1, 1, 1, 4, 0, 0), "t1e");
    chk("t1_mem_fwd_a", s_fa, 2'd2);
    repeat (2) run(nop, "gap");
    run(mk(1, 1, 0, 1, 0, 1, 6, 1, 0), "t2a");
    run(mk(1, 6, 6, 1, 1, 1, 7, 0, 0), "t2b");
    chk("t2_loaduse_stall", {1'b0, s_stall}, 2'd1);
    run(mk(1, 6, 6, 1, 1, 1, 7, 0, 0), "t2c");
    chk("t2_resume_stall", {1'b0, s_stall}, 2'd0);
    chk("t2_fwd_a", s_fa, 2'd3);
    chk("t2_fwd_b", s_fb, 2'd3);
`else
    run(mk(1, 1, 2, 1, 1, 1, 3, 0, 0), "t5a");
    run(mk(1, 3, 1, 1, 1, 1, 4, 0, 0), "t5b");
    chk("t5_stall1", {1'b0, s_stall}, 2'd1);
    run(mk(1, 3, 1, 1, 1, 1, 4, 0, 0), "t5c");
    chk("t5_stall2", {1'b0, s_stall}, 2'd1);
    chk("t5_fwd_a", s_fa, 2'd0);
    run(mk(1, 3, 1, 1, 1, 1, 4, 0, 0), "t5d");
    chk("t5_release", {1'b0, s_stall}, 2'd0);
`endif
    repeat (2) run(nop, "gap");

    run(mk(1, 1, 2, 1, 1, 1, 8, 0, 1), "t3a");
    run(nop, "t3b");
    chk("t3_busy1", {1'b0, s_busy}, 2'd1);
    run(nop, "t3c");
    chk("t3_busy2", {1'b0, s_stall}, 2'd1);
    run(nop, "t3d");
    chk("t3_done", {1'b0, s_busy}, 2'd0);
    repeat (2) run(nop, "gap");

    // Reset while the multiply counter is mid-count
    run(mk(1, 1, 2, 1, 1, 1, 8, 0, 1), "t6a");
    run(mk(1, 8, 8, 1, 1, 1, 9, 0, 0), "t6b");
    id_valid = 1; id_rs = 5'd8; id_rt = 5'd8; id_use_rs = 1; id_use_rt = 1;
    id_wreg = 1; id_dst = 5'd9; id_load = 0; id_mul = 0;
    #1;
    chk("t6_pre_busy", {1'b0, mul_busy}, 2'd1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_stall", {1'b0, stall}, 2'd0);
    chk("t6_rst_busy", {1'b0, mul_busy}, 2'd0);
    chk("t6_rst_fwd_a", fwd_a, 2'd0);
    chk("t6_rst_fwd_b", fwd_b, 2'd0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    run(mk(1, 8, 8, 1, 1, 1, 9, 0, 0), "t6c");
    chk("t6_after_stall", {1'b0, s_stall}, 2'd0);

    for (int n = 0; n < 400; n++) begin
      ins_t r;
      r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 7), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      run(r, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
